// File: rtl/bcd_counter.sv
// Up/down BCD counter with DIGITS cascaded decades and a terminal-count flag.
// Optional synchronous parallel load is enabled by defining BCD_COUNTER_LOAD_EN.
module bcd_counter #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
`ifdef BCD_COUNTER_LOAD_EN
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc
);

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_d;
    logic [4*DIGITS-1:0] step_val;
    logic                carry;
    logic                all9;
    logic                all0;

    function automatic logic [3:0] digit_inc(input logic [3:0] dig);
        return (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] dig);
        return (dig == 4'd0 || dig > 4'd9) ? 4'd9 : dig - 4'd1;
    endfunction

    function automatic logic [3:0] digit_clean(input logic [3:0] dig);
        return (dig > 4'd9) ? 4'd0 : dig;
    endfunction

    // Ripple carry/borrow: a digit moves only while every lower digit sits at its limit.
    always_comb begin
        step_val = count_q;
        carry    = 1'b1;
        all9     = 1'b1;
        all0     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                step_val[4*i +: 4] = sel ? digit_inc(count_q[4*i +: 4])
                                         : digit_dec(count_q[4*i +: 4]);
            end
            carry = carry && (sel ? (count_q[4*i +: 4] == 4'd9)
                                  : (count_q[4*i +: 4] == 4'd0));
            all9  = all9 && (count_q[4*i +: 4] == 4'd9);
            all0  = all0 && (count_q[4*i +: 4] == 4'd0);
        end
    end

`ifdef BCD_COUNTER_LOAD_EN
    always_comb begin
        count_d = step_val;
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                count_d[4*i +: 4] = digit_clean(d[4*i +: 4]);
            end
        end
    end
`else
    assign count_d = step_val;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q  = count_q;
    assign tc = sel ? all9 : all0;

endmodule

// File: tb/tb_bcd_counter.sv
// Randomized bench for bcd_counter: DIGITS=1 and DIGITS=2 instances checked
// every cycle against an integer-modulo reference model.
module tb_bcd_counter;

    logic       clk;
    logic       rst;
    logic       sel1;
    logic       sel2;
    logic [3:0] q1;
    logic [7:0] q2;
    logic       tc1;
    logic       tc2;
`ifdef BCD_COUNTER_LOAD_EN
    logic       load;
    logic [3:0] d1;
    logic [7:0] d2;
`endif

    int errors = 0;
    int checks = 0;
    int m1 = 0;
    int m2 = 0;

    bcd_counter #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .sel(sel1),
`ifdef BCD_COUNTER_LOAD_EN
        .load(load), .d(d1),
`endif
        .q(q1), .tc(tc1)
    );

    bcd_counter #(.DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .sel(sel2),
`ifdef BCD_COUNTER_LOAD_EN
        .load(load), .d(d2),
`endif
        .q(q2), .tc(tc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < n; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clean(input logic [31:0] b, input int n);
        int v = 0;
        int w = 1;
        for (int i = 0; i < n; i++) begin
            int dig = int'((b >> (4 * i)) & 32'hF);
            if (dig > 9) dig = 0;
            v = v + dig * w;
            w = w * 10;
        end
        return v;
    endfunction

    function automatic int next_val(input int v, input logic up, input int modn);
        return up ? (v + 1) % modn : (v + modn - 1) % modn;
    endfunction

    task automatic check_q();
        check("q1", 32'(q1), to_bcd(m1, 1));
        check("q2", 32'(q2), to_bcd(m2, 2));
    endtask

    task automatic check_tc();
        check("tc1", 32'(tc1), 32'(sel1 ? (m1 == 9) : (m1 == 0)));
        check("tc2", 32'(tc2), 32'(sel2 ? (m2 == 99) : (m2 == 0)));
    endtask

    // Called at a falling edge: apply directions, check tc, clock once, check q.
    task automatic step(input logic s1, input logic s2);
        sel1 = s1;
        sel2 = s2;
        #1;
        check_tc();
        @(posedge clk);
        m1 = next_val(m1, s1, 10);
        m2 = next_val(m2, s2, 100);
        @(negedge clk);
        check_q();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        m1 = 0;
        m2 = 0;
        check_q();
        @(posedge clk);
        #1;
        check_q();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        sel1 = 1'b1;
        sel2 = 1'b1;
`ifdef BCD_COUNTER_LOAD_EN
        load = 1'b0;
        d1   = '0;
        d2   = '0;
`endif
        repeat (2) @(negedge clk);
        check_q();
        rst = 1'b1;

        // Up to 7, then asynchronous reset mid-cycle, then 1,2,3.
        repeat (7) step(1'b1, 1'b1);
        @(posedge clk);
        #2;
        async_reset();
        repeat (3) step(1'b1, 1'b1);

        // Up wrap for one digit, down wrap afterwards.
        repeat (12) step(1'b1, 1'b1);
        async_reset();
        repeat (12) step(1'b0, 1'b0);

        // Direction switch around 5.
        async_reset();
        repeat (6) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Two-digit cascade: up to 98, through 99 to 00, then 10 and down.
        async_reset();
        repeat (98) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Random direction per cycle, independent per instance.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom), 1'($urandom));
            if (n == 200) async_reset();
        end

`ifdef BCD_COUNTER_LOAD_EN
        for (int n = 0; n < 40; n++) begin
            logic [7:0] rv;
            rv   = 8'($urandom);
            d1   = rv[3:0];
            d2   = 8'($urandom);
            load = (n % 3 == 0) || (n < 2);
            if (n == 0) d1 = 4'hC;
            if (n == 1) d1 = 4'h7;
            sel1 = 1'b1;
            sel2 = 1'($urandom);
            #1;
            check_tc();
            @(posedge clk);
            if (load) begin
                m1 = from_bcd_clean(32'(d1), 1);
                m2 = from_bcd_clean(32'(d2), 2);
            end else begin
                m1 = next_val(m1, sel1, 10);
                m2 = next_val(m2, sel2, 100);
            end
            @(negedge clk);
            check_q();
            load = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
